adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//  Parametrised successor of the registered 4-bit adder: WIDTH-bit add/sub/accumulate
//  unit with 2-stage pipeline and valid/ready handshake on both sides. Sits between
//  operand producers (counters, sequencers) and result consumers; reports carry and
//  signed overflow. Throughput 1 result/cycle when downstream is ready.
// PARAMETERS
//  WIDTH       4   operand/result width in bits (>=2)
//  SAT_SIGNED  1   saturation view when ADDER_PIPE_SAT_EN set: 1 = signed, 0 = unsigned
// PORTS
//  Clk        in   1      rising-edge clock, single clock domain
//  Rst_n      in   1      asynchronous, active-low reset
//  En         in   1      global enable; 0 = whole pipeline holds, no handshakes complete
//  In_Valid   in   1      operand beat valid
//  In_Ready   out  1      unit accepts a beat this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Mode       in   2      00 ADD A+B, 01 SUB A-B, 10 ACC acc+A, 11 LOAD acc=A (result A)
//  Out_Valid  out  1      result valid
//  Out_Ready  in   1      consumer accepts result
//  Sum        out  WIDTH  result
//  Carry      out  1      carry out of the WIDTH-bit add (SUB: 1 = no borrow)
//  Overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async, Rst_n=0): s1/s2 valid=0, acc=0; Out_Valid=0, Sum=0, Carry=0,
//    Overflow=0, In_Ready=0 while in reset, In_Ready=1 first cycle after release.
//  - Stage 1 registers {A,B,Mode}; stage 2 computes and registers {Sum,Carry,Overflow}.
//  - Handshake: beat accepted iff In_Valid & In_Ready & En; result consumed iff
//    Out_Valid & Out_Ready & En. Latency accept->Out_Valid = 2 cycles.
//  - Advance: s2 loads when En & (!s2_valid | Out_Ready); s1 loads when En &
//    (!s1_valid | s2 loads). In_Ready = En & (!s1_valid | s2 loads) (no bubbles).
//  - Out_Valid/Sum/Carry/Overflow held stable while Out_Valid & !Out_Ready.
//  - Arithmetic in WIDTH+1 bits: ADD {C,S}=A+B; SUB {C,S}=A+~B+1; ACC {C,S}=acc+A;
//    LOAD S=A, C=0, V=0. V = (opA[msb]==opB'[msb]) & (S[msb]!=opA[msb]), opB' the
//    effective addend (~B for SUB). Wrap-around modulo 2^WIDTH.
//  - acc updated only when an ACC/LOAD beat loads stage 2: acc <= Sum (post-sat).
//    Back-to-back ACC beats see the previous beat's acc (forwarded, no hazard).
//  - En=0 mid-operation: all state frozen, no beat lost or duplicated.
//  - Out_Ready=1 with s2 full and new s1 beat: s2 replaced same edge, In_Ready stays 1.
// CONFIGURATION
//  - ADDER_PIPE_SAT_EN defined: on overflow Sum clamps instead of wrapping.
//    SAT_SIGNED=1: clamp to 0111..1 / 1000..0 per sign of A; trigger = V.
//    SAT_SIGNED=0: ADD/ACC clamp to 11..1 on C=1, SUB clamp to 0 on C=0.
//    Carry/Overflow flags still report the unsaturated condition.
//  - Not defined: pure modular wrap; SAT_SIGNED ignored.
// STRUCTURE
//  - Package adder_pipe_pkg: mode_e enum (MODE_ADD, MODE_SUB, MODE_ACC, MODE_LOAD),
//    MODE_W=2 localparam.
//  - Sub-module adder_pipe_alu: combinational WIDTH-bit add/sub/ovf/sat; this module
//    holds the pipeline registers, acc register and handshake control.
// TESTING (WIDTH=4, SAT_SIGNED=1)
//  - ADD A=7,B=9, Out_Ready=1 -> Out_Valid 2 cycles later, Sum=0, Carry=1, Ovf=0.
//  - ADD A=7,B=1 -> Sum=8, Ovf=1 (sat build: Sum=7); SUB A=3,B=5 -> Sum=14, Carry=0.
//  - LOAD 5, ACC 4, ACC 4 back-to-back -> Sums 5,9,13; acc=13 (sat: 5,7,7).
//  - Out_Ready=0 for 4 cycles, 3 beats offered -> 2 accepted, In_Ready=0, Sum held;
//    release -> all beats emerge in order, none dropped or repeated.
//  - En=0 for 3 cycles mid-stream -> outputs/state frozen, resumes identically.
//  - Rst_n low mid-stream with Out_Valid=1 -> Out_Valid=0, acc=0 immediately (async).

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// adder_pipe_pkg
// Shared types and constants for the adder_pipe block.
//   mode_e  : operation selector carried with every operand beat
//             (ADD A+B, SUB A-B, ACC acc+A, LOAD acc=A)
//   MODE_W  : width of the Mode field on the operand interface
// Build option: ADDER_PIPE_SAT_EN (see adder_pipe_alu) selects saturating
// results instead of modular wrap-around.
// -----------------------------------------------------------------------------
package adder_pipe_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/adder_pipe_if.sv
// -----------------------------------------------------------------------------
// adder_pipe_if
// Operand and result channels of adder_pipe.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid & ready & En are all 1. The sender holds valid and its payload
// stable until that edge; ready may change at any time and never depends on
// the sender lowering valid.
//
//   In_Valid  / In_Ready   operand beat {A, B, Mode}
//   Out_Valid / Out_Ready  result beat  {Sum, Carry, Overflow}
//
// Modports:
//   master : operand producer + result consumer (drives In_*, Out_Ready)
//   slave  : the adder_pipe unit
// -----------------------------------------------------------------------------
interface adder_pipe_if #(
    parameter int WIDTH = 4
);
    import adder_pipe_pkg::*;

    logic                 In_Valid;
    logic                 In_Ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [MODE_W-1:0]    Mode;

    logic                 Out_Valid;
    logic                 Out_Ready;
    logic [WIDTH-1:0]     Sum;
    logic                 Carry;
    logic                 Overflow;

    modport master (
        output In_Valid, A, B, Mode, Out_Ready,
        input  In_Ready, Out_Valid, Sum, Carry, Overflow
    );

    modport slave (
        input  In_Valid, A, B, Mode, Out_Ready,
        output In_Ready, Out_Valid, Sum, Carry, Overflow
    );

endinterface

// File: rtl/adder_pipe_alu.sv
// -----------------------------------------------------------------------------
// adder_pipe_alu
// Combinational WIDTH-bit add / subtract / accumulate / load with carry,
// signed overflow and optional saturation.
//
// Ports:
//   a, b      in   operands from stage 1
//   acc       in   current accumulator value (used by ACC)
//   mode      in   operation select (mode_e)
//   sum       out  result (saturated when the build enables it)
//   carry     out  carry out of the WIDTH-bit add; for SUB 1 means no borrow
//   overflow  out  two's-complement overflow of the unsaturated add
//
// Build option ADDER_PIPE_SAT_EN: when defined, an overflowing result clamps.
//   SAT_SIGNED=1 : trigger is overflow; clamp to max positive / min negative
//                  according to the sign of the first operand.
//   SAT_SIGNED=0 : ADD/ACC clamp to all-ones on carry, SUB clamps to zero on
//                  borrow (carry=0).
// Without the macro the result wraps modulo 2^WIDTH and SAT_SIGNED is inert.
// carry/overflow always describe the unsaturated operation.
// -----------------------------------------------------------------------------
module adder_pipe_alu
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit SAT_SIGNED = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  mode_e            mode,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int MSB = WIDTH - 1;

    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {MSB{1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {MSB{1'b0}}};

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;      // effective addend (~b for SUB)
    logic             cin;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] raw_sum;
    logic             raw_carry;
    logic             raw_ovf;

    // Operand steering: every mode reduces to op_a + op_b + cin.
    always_comb begin
        op_a = a;
        op_b = b;
        cin  = 1'b0;
        case (mode)
            MODE_ADD:  ;
            MODE_SUB: begin
                op_b = ~b;
                cin  = 1'b1;
            end
            MODE_ACC: begin
                op_a = acc;
                op_b = a;
            end
            MODE_LOAD: begin
                op_b = '0;
            end
            default: ;
        endcase
    end

    assign sum_ext   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    assign raw_sum   = sum_ext[WIDTH-1:0];
    assign raw_carry = sum_ext[WIDTH];
    assign raw_ovf   = (op_a[MSB] == op_b[MSB]) && (raw_sum[MSB] != op_a[MSB]);

    always_comb begin
        sum      = raw_sum;
        carry    = raw_carry;
        overflow = raw_ovf;
        if (mode == MODE_LOAD) begin
            sum      = a;
            carry    = 1'b0;
            overflow = 1'b0;
        end else if (SAT_EN) begin
            if (SAT_SIGNED) begin
                // Overflow implies both operands share op_a's sign.
                if (raw_ovf) begin
                    sum = op_a[MSB] ? S_MIN : S_MAX;
                end
            end else if (mode == MODE_SUB) begin
                if (!raw_carry) begin
                    sum = '0;
                end
            end else if (raw_carry) begin
                sum = '1;
            end
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
// Two-stage WIDTH-bit add/sub/accumulate unit with valid/ready on both sides.
// Stage 1 registers the operand beat {A, B, Mode}; stage 2 registers the ALU
// result {Sum, Carry, Overflow}. One result per cycle while the consumer is
// ready; accept-to-Out_Valid latency is two cycles.
//
// Ports:
//   Clk       in   rising-edge clock
//   Rst_n     in   asynchronous active-low reset
//   En        in   global enable; 0 freezes every register and blocks both
//                  handshakes
//   bus       slave modport of adder_pipe_if (operand and result channels)
//   dbg_acc   out  current accumulator value, for observation only
//
// Build option ADDER_PIPE_SAT_EN: saturating results (see adder_pipe_alu).
// -----------------------------------------------------------------------------
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit SAT_SIGNED = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    adder_pipe_if.slave      bus,
    output logic [WIDTH-1:0] dbg_acc
);

    // Stage 1: operand registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    mode_e            s1_mode_q,  s1_mode_d;

    // Stage 2: result registers
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sum_q,   s2_sum_d;
    logic             s2_carry_q, s2_carry_d;
    logic             s2_ovf_q,   s2_ovf_d;

    // Accumulator and "out of reset" flag. The flag keeps In_Ready low while
    // reset is asserted and raises it on the first edge after release.
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic             live_q,     live_d;

    logic             s2_load;
    logic             s1_load;
    logic             accept;

    logic [WIDTH-1:0] alu_sum;
    logic             alu_carry;
    logic             alu_ovf;

    adder_pipe_alu #(
        .WIDTH      (WIDTH),
        .SAT_SIGNED (SAT_SIGNED)
    ) u_alu (
        .a        (s1_a_q),
        .b        (s1_b_q),
        .acc      (acc_q),
        .mode     (s1_mode_q),
        .sum      (alu_sum),
        .carry    (alu_carry),
        .overflow (alu_ovf)
    );

    // Stage 2 advances when empty or drained this edge; stage 1 advances when
    // empty or moving into stage 2, so a full pipe still takes a new beat
    // every cycle the consumer is ready.
    always_comb begin
        s2_load = En && (!s2_valid_q || bus.Out_Ready);
        s1_load = En && live_q && (!s1_valid_q || s2_load);
        accept  = bus.In_Valid && s1_load;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_carry_d = s2_carry_q;
        s2_ovf_d   = s2_ovf_q;
        acc_d      = acc_q;
        live_d     = 1'b1;

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d    = bus.A;
                s1_b_d    = bus.B;
                s1_mode_d = mode_e'(bus.Mode);
            end
        end

        // Result fields only change when a real beat moves in, so a bubble
        // leaves the last result on Sum/Carry/Overflow.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d   = alu_sum;
                s2_carry_d = alu_carry;
                s2_ovf_d   = alu_ovf;
                // acc updates on the same edge the beat enters stage 2, so
                // the next ACC beat sitting in stage 1 already sees it.
                if (s1_mode_q == MODE_ACC || s1_mode_q == MODE_LOAD) begin
                    acc_d = alu_sum;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_ADD;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_carry_q <= 1'b0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
            live_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_carry_q <= s2_carry_d;
            s2_ovf_q   <= s2_ovf_d;
            acc_q      <= acc_d;
            live_q     <= live_d;
        end
    end

    assign bus.In_Ready  = s1_load;
    assign bus.Out_Valid = s2_valid_q;
    assign bus.Sum       = s2_sum_q;
    assign bus.Carry     = s2_carry_q;
    assign bus.Overflow  = s2_ovf_q;
    assign dbg_acc       = acc_q;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
// Directed bench for adder_pipe at WIDTH=4, SAT_SIGNED=1. Expected values are
// hand-computed; the saturating build (ADDER_PIPE_SAT_EN) selects the clamped
// variants. Results are packed {Overflow, Carry, Sum}.
// -----------------------------------------------------------------------------
module tb_adder_pipe;
    import adder_pipe_pkg::*;

    localparam int WIDTH = 4;
`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             Clk;
    logic             Rst_n;
    logic             En;
    logic [WIDTH-1:0] dbg_acc;

    adder_pipe_if #(.WIDTH(WIDTH)) bus ();

    adder_pipe #(
        .WIDTH      (WIDTH),
        .SAT_SIGNED (1'b1)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .En      (En),
        .bus     (bus),
        .dbg_acc (dbg_acc)
    );

    int checks = 0;
    int errors = 0;

    logic [5:0] got_q[$];   // consumed results {ovf, carry, sum}

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record every consumed result; inputs settle #1 after posedge, so the
    // negedge sees exactly what the next posedge will act on.
    always @(negedge Clk) begin
        if (Rst_n && En && bus.Out_Valid && bus.Out_Ready)
            got_q.push_back({bus.Overflow, bus.Carry, bus.Sum});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        bit ok = 1'b0;
        bus.In_Valid = 1'b1;
        bus.Mode     = m;
        bus.A        = a;
        bus.B        = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (bus.In_Ready && En) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge Clk);
        #1;
        bus.In_Valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: In_Ready never seen for mode %0d a %0d b %0d", m, a, b);
        end
    endtask

    task automatic wait_results(input int n);
        for (int c = 0; c < 50 && got_q.size() < n; c++)
            @(posedge Clk);
        @(posedge Clk);
        #1;
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL result_timeout: got %0d results, required %0d", got_q.size(), n);
        end
    endtask

    task automatic drain();
        bus.Out_Ready = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        got_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Rst_n = 1'b0;
        En = 1'b1;
        bus.In_Valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Mode = MODE_ADD;
        bus.Out_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks += 6;
        if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", bus.Out_Valid); end
        if (bus.Sum !== 4'd0) begin errors++; $display("FAIL rst_sum: got %0d exp 0", bus.Sum); end
        if (bus.Carry !== 1'b0) begin errors++; $display("FAIL rst_carry: got %b exp 0", bus.Carry); end
        if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", bus.Overflow); end
        if (bus.In_Ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", bus.In_Ready); end
        if (dbg_acc !== 4'd0) begin errors++; $display("FAIL rst_acc: got %0d exp 0", dbg_acc); end
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (bus.In_Ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b exp 1", bus.In_Ready); end
    endtask

    // ADD 7+9: accepted in cycle k, Out_Valid in cycle k+2.
    task automatic test_add_latency();
        bus.In_Valid = 1'b1;
        bus.Mode = MODE_ADD;
        bus.A = 4'd7;
        bus.B = 4'd9;
        @(negedge Clk);
        checks++;
        if (bus.In_Ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b exp 1", bus.In_Ready); end
        @(posedge Clk);
        #1;
        bus.In_Valid = 1'b0;
        checks++;
        if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b exp 0", bus.Out_Valid); end
        @(posedge Clk);
        #1;
        checks += 4;
        if (bus.Out_Valid !== 1'b1) begin errors++; $display("FAIL lat_out_valid: got %b exp 1", bus.Out_Valid); end
        if (bus.Sum !== 4'd0) begin errors++; $display("FAIL add79_sum: got %0d exp 0", bus.Sum); end
        if (bus.Carry !== 1'b1) begin errors++; $display("FAIL add79_carry: got %b exp 1", bus.Carry); end
        if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL add79_ovf: got %b exp 0", bus.Overflow); end
        drain();
    endtask

    // ADD 7+1 (signed overflow), SUB 3-5 (borrow), back-to-back.
    task automatic test_ovf_sub();
        logic [5:0] exp_r[2];
        exp_r[0] = {1'b1, 1'b0, (SAT ? 4'd7 : 4'd8)};
        exp_r[1] = {1'b0, 1'b0, 4'd14};
        send_beat(MODE_ADD, 4'd7, 4'd1);
        send_beat(MODE_SUB, 4'd3, 4'd5);
        wait_results(2);
        for (int i = 0; i < 2; i++) begin
            logic [5:0] g;
            g = (i < got_q.size()) ? got_q[i] : 6'bx;
            checks++;
            if (g !== exp_r[i]) begin
                errors++;
                $display("FAIL ovf_sub_%0d: got %h exp %h", i, g, exp_r[i]);
            end
        end
        drain();
    endtask

    // LOAD 5, ACC 4, ACC 4 back-to-back: accumulator forwarding.
    task automatic test_acc();
        logic [5:0] exp_r[3];
        exp_r[0] = {1'b0, 1'b0, 4'd5};
        exp_r[1] = {1'b1, 1'b0, (SAT ? 4'd7 : 4'd9)};
        exp_r[2] = SAT ? {1'b1, 1'b0, 4'd7} : {1'b0, 1'b0, 4'd13};
        send_beat(MODE_LOAD, 4'd5, 4'd0);
        send_beat(MODE_ACC, 4'd4, 4'd0);
        send_beat(MODE_ACC, 4'd4, 4'd0);
        wait_results(3);
        for (int i = 0; i < 3; i++) begin
            logic [5:0] g;
            g = (i < got_q.size()) ? got_q[i] : 6'bx;
            checks++;
            if (g !== exp_r[i]) begin
                errors++;
                $display("FAIL acc_%0d: got %h exp %h", i, g, exp_r[i]);
            end
        end
        checks++;
        if (dbg_acc !== (SAT ? 4'd7 : 4'd13)) begin
            errors++;
            $display("FAIL acc_final: got %0d exp %0d", dbg_acc, (SAT ? 7 : 13));
        end
        drain();
    endtask

    // Out_Ready low for 4 cycles with 3 beats offered: only 2 fit.
    task automatic test_backpressure();
        logic [1:0] tm[3];
        logic [3:0] ta[3];
        logic [3:0] tb[3];
        logic [5:0] exp_r[3];
        int idx = 0;
        tm[0] = MODE_ADD; ta[0] = 4'd1; tb[0] = 4'd2;
        tm[1] = MODE_SUB; ta[1] = 4'd6; tb[1] = 4'd1;
        tm[2] = MODE_ADD; ta[2] = 4'd2; tb[2] = 4'd2;
        exp_r[0] = {1'b0, 1'b0, 4'd3};
        exp_r[1] = {1'b0, 1'b1, 4'd5};
        exp_r[2] = {1'b0, 1'b0, 4'd4};
        bus.Out_Ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bit go;
            bus.In_Valid = 1'b1;
            bus.Mode = tm[idx];
            bus.A = ta[idx];
            bus.B = tb[idx];
            @(negedge Clk);
            go = bus.In_Ready;
            if (c >= 2) begin
                checks += 2;
                if (bus.Out_Valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b exp 1", c, bus.Out_Valid); end
                if (bus.Sum !== 4'd3) begin errors++; $display("FAIL bp_sum_held_c%0d: got %0d exp 3", c, bus.Sum); end
            end
            @(posedge Clk);
            #1;
            if (go) idx++;
        end
        checks += 3;
        if (idx != 2) begin errors++; $display("FAIL bp_accepted: got %0d exp 2", idx); end
        if (bus.In_Ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b exp 0", bus.In_Ready); end
        if (got_q.size() != 0) begin errors++; $display("FAIL bp_consumed: got %0d exp 0", got_q.size()); end
        bus.Out_Ready = 1'b1;
        send_beat(tm[2], ta[2], tb[2]);
        wait_results(3);
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [5:0] g;
            g = (i < got_q.size()) ? got_q[i] : 6'bx;
            checks++;
            if (g !== exp_r[i]) begin
                errors++;
                $display("FAIL bp_order_%0d: got %h exp %h", i, g, exp_r[i]);
            end
        end
        drain();
    endtask

    // En low for 3 cycles with one beat in each stage and a third waiting.
    task automatic test_enable();
        logic [5:0] exp_r[3];
        exp_r[0] = {1'b0, 1'b0, 4'd7};
        exp_r[1] = {1'b0, 1'b0, 4'd15};
        exp_r[2] = {1'b1, 1'b1, (SAT ? 4'd8 : 4'd0)};
        send_beat(MODE_ADD, 4'd3, 4'd4);
        send_beat(MODE_SUB, 4'd2, 4'd3);
        En = 1'b0;
        bus.In_Valid = 1'b1;
        bus.Mode = MODE_ADD;
        bus.A = 4'd8;
        bus.B = 4'd8;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            checks += 3;
            if (bus.Out_Valid !== 1'b1) begin errors++; $display("FAIL en_valid_c%0d: got %b exp 1", c, bus.Out_Valid); end
            if (bus.Sum !== 4'd7) begin errors++; $display("FAIL en_sum_c%0d: got %0d exp 7", c, bus.Sum); end
            if (bus.In_Ready !== 1'b0) begin errors++; $display("FAIL en_in_ready_c%0d: got %b exp 0", c, bus.In_Ready); end
            @(posedge Clk);
            #1;
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL en_consumed: got %0d exp 0", got_q.size()); end
        En = 1'b1;
        send_beat(MODE_ADD, 4'd8, 4'd8);
        wait_results(3);
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL en_count: got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [5:0] g;
            g = (i < got_q.size()) ? got_q[i] : 6'bx;
            checks++;
            if (g !== exp_r[i]) begin
                errors++;
                $display("FAIL en_order_%0d: got %h exp %h", i, g, exp_r[i]);
            end
        end
        drain();
    endtask

    // Reset asserted between edges while a result is waiting.
    task automatic test_async_reset();
        bus.Out_Ready = 1'b0;
        send_beat(MODE_LOAD, 4'd6, 4'd0);
        @(posedge Clk);
        #1;
        checks += 2;
        if (bus.Out_Valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b exp 1", bus.Out_Valid); end
        if (dbg_acc !== 4'd6) begin errors++; $display("FAIL ar_pre_acc: got %0d exp 6", dbg_acc); end
        #2;
        Rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b exp 0", bus.Out_Valid); end
        if (bus.Sum !== 4'd0) begin errors++; $display("FAIL ar_sum: got %0d exp 0", bus.Sum); end
        if (dbg_acc !== 4'd0) begin errors++; $display("FAIL ar_acc: got %0d exp 0", dbg_acc); end
        if (bus.In_Ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready: got %b exp 0", bus.In_Ready); end
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        bus.Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        got_q.delete();
        send_beat(MODE_ACC, 4'd2, 4'd0);
        wait_results(1);
        checks++;
        if (got_q.size() < 1 || got_q[0] !== 6'b00_0010) begin
            errors++;
            $display("FAIL ar_acc_after: got %h exp 02", (got_q.size() > 0) ? got_q[0] : 6'bx);
        end
        drain();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_add_latency();
        test_ovf_sub();
        test_acc();
        test_backpressure();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
